scan_sel_gen: RTL and testbench

Digit-scan select generator that sits directly upstream of the 3-to-8 select decoder. It cycles a 3-bit select over digits 0..i_last and holds each digit for a programmable dwell time. Between digits it inserts a fixed blanking gap, during which downstream logic forces all select lines inactive to suppress ghosting. It also emits per-digit and per-frame strobes for the display data path.

---
 rtl/scan_sel_gen_pkg.sv | 12 +
 rtl/scan_sel_gen.sv | 149 ++++++++++++++
 tb/tb_scan_sel_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/scan_sel_gen_pkg.sv
// Shared constants for the digit-scan select generator.
//   SEL_W         : width of the digit select bus (feeds a 3-to-8 decoder)
//   StIdle/StDwell/StBlank : scan FSM state encodings
package scan_sel_gen_pkg;

   localparam int unsigned SEL_W = 3;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StDwell = 2'd1;
   localparam logic [1:0] StBlank = 2'd2;

endpackage

// File: rtl/scan_sel_gen.sv
// Digit-scan select generator. Cycles o_sel over digits 0..i_last, holding each digit for
// i_div+1 cycles, then inserts BLANK_CYC blanking cycles before moving to the next digit.
// Ports:
//   i_clk   : system clock, all state on rising edge
//   i_rst   : asynchronous active-high reset
//   i_en    : scan enable; low returns to idle (digit 0, blanked)
//   i_div   : dwell length minus 1, latched at the start of every digit
//   i_last  : highest digit index scanned, sampled at every advance
//   o_sel   : current digit select
//   o_blank : all digits must be off while high
//   o_tick  : one-cycle pulse on the first cycle of each digit
//   o_frame : one-cycle pulse when o_sel wraps to 0 (coincides with o_tick)
module scan_sel_gen
   import scan_sel_gen_pkg::*;
#(
   parameter int unsigned DIV_W     = 16,
   parameter int unsigned BLANK_CYC = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic [DIV_W-1:0] i_div,
   input  logic [SEL_W-1:0] i_last,
   output logic [SEL_W-1:0] o_sel,
   output logic             o_blank,
   output logic             o_tick,
   output logic             o_frame
);

   localparam bit         HasBlank  = (BLANK_CYC != 0);
   // Terminal value of the blank counter; unused when there is no blanking.
   localparam logic [7:0] BlankLast = HasBlank ? 8'(BLANK_CYC - 1) : 8'd0;

   logic [1:0]       state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             blank_q, blank_d;
   logic             tick_q, tick_d;
   logic             frame_q, frame_d;
   logic [DIV_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [7:0]       blank_cnt_q, blank_cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             advance;

   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      blank_d     = blank_q;
      tick_d      = 1'b0;
      frame_d     = 1'b0;
      dwell_cnt_d = dwell_cnt_q;
      blank_cnt_d = blank_cnt_q;
      div_d       = div_q;
      advance     = 1'b0;

      if (!i_en) begin
         state_d     = StIdle;
         sel_d       = '0;
         blank_d     = 1'b1;
         dwell_cnt_d = '0;
         blank_cnt_d = '0;
      end else begin
         case (state_q)
            StIdle: begin
               // Start at digit 0; the first digit always counts as a frame start.
               state_d     = StDwell;
               sel_d       = '0;
               blank_d     = 1'b0;
               tick_d      = 1'b1;
               frame_d     = 1'b1;
               div_d       = i_div;
               dwell_cnt_d = '0;
            end
            StDwell: begin
               if (dwell_cnt_q == div_q) begin
                  dwell_cnt_d = '0;
                  if (HasBlank) begin
                     state_d     = StBlank;
                     blank_d     = 1'b1;
                     blank_cnt_d = '0;
                  end else begin
                     advance = 1'b1;
                  end
               end else begin
                  dwell_cnt_d = dwell_cnt_q + 1'b1;
               end
            end
            StBlank: begin
               if (blank_cnt_q == BlankLast) begin
                  blank_cnt_d = '0;
                  advance     = 1'b1;
               end else begin
                  blank_cnt_d = blank_cnt_q + 8'd1;
               end
            end
            default: begin
               state_d     = StIdle;
               sel_d       = '0;
               blank_d     = 1'b1;
               dwell_cnt_d = '0;
               blank_cnt_d = '0;
            end
         endcase

         if (advance) begin
            // >= so that lowering i_last below the current digit wraps instead of
            // running through out-of-range indices.
            if (sel_q >= i_last) begin
               sel_d   = '0;
               frame_d = 1'b1;
            end else begin
               sel_d = sel_q + 1'b1;
            end
            state_d     = StDwell;
            tick_d      = 1'b1;
            blank_d     = 1'b0;
            div_d       = i_div;
            dwell_cnt_d = '0;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= StIdle;
         sel_q       <= '0;
         blank_q     <= 1'b1;
         tick_q      <= 1'b0;
         frame_q     <= 1'b0;
         dwell_cnt_q <= '0;
         blank_cnt_q <= '0;
         div_q       <= '0;
      end else begin
         state_q     <= state_d;
         sel_q       <= sel_d;
         blank_q     <= blank_d;
         tick_q      <= tick_d;
         frame_q     <= frame_d;
         dwell_cnt_q <= dwell_cnt_d;
         blank_cnt_q <= blank_cnt_d;
         div_q       <= div_d;
      end
   end

   assign o_sel   = sel_q;
   assign o_blank = blank_q;
   assign o_tick  = tick_q;
   assign o_frame = frame_q;

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: instance a has 4 blanking cycles, instance b has none.
// Expected output streams are built from the scan timing rules and queued, then popped
// one entry per clock and compared against the selected instance.
module tb_scan_sel_gen;

   logic        clk;
   logic        rst;
   logic        en;
   logic [15:0] div;
   logic [2:0]  last;

   logic [2:0]  sel_a, sel_b;
   logic        blank_a, blank_b, tick_a, tick_b, frame_a, frame_b;

   scan_sel_gen #(.DIV_W(16), .BLANK_CYC(4)) u_dut_a (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_en    (en),
      .i_div   (div),
      .i_last  (last),
      .o_sel   (sel_a),
      .o_blank (blank_a),
      .o_tick  (tick_a),
      .o_frame (frame_a)
   );

   scan_sel_gen #(.DIV_W(16), .BLANK_CYC(0)) u_dut_b (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_en    (en),
      .i_div   (div),
      .i_last  (last),
      .o_sel   (sel_b),
      .o_blank (blank_b),
      .o_tick  (tick_b),
      .o_frame (frame_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] sel;
      logic       blank;
      logic       tick;
      logic       frame;
   } exp_t;

   exp_t exp_q[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   localparam logic [5:0] IdleVec = 6'b000_1_0_0;

   wire [5:0] obs_a = {sel_a, blank_a, tick_a, frame_a};
   wire [5:0] obs_b = {sel_b, blank_b, tick_b, frame_b};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed sel/blank/tick/frame=%b required %b", tag, obs, expv);
      end
   endtask

   // Queue the expected per-cycle outputs of n digits starting at digit 'start'.
   task automatic gen(input int dv, input int lst, input int bc, input int start, input int n,
                      input bit frame0);
      int   d;
      bit   fr;
      exp_t e;
      d  = start;
      fr = frame0;
      for (int i = 0; i < n; i++) begin
         for (int c = 0; c <= dv; c++) begin
            e.sel   = 3'(d);
            e.blank = 1'b0;
            e.tick  = (c == 0);
            e.frame = (c == 0) && fr;
            exp_q.push_back(e);
         end
         for (int b = 0; b < bc; b++) begin
            e.sel   = 3'(d);
            e.blank = 1'b1;
            e.tick  = 1'b0;
            e.frame = 1'b0;
            exp_q.push_back(e);
         end
         if (d >= lst) begin
            d  = 0;
            fr = 1'b1;
         end else begin
            d++;
            fr = 1'b0;
         end
      end
   endtask

   task automatic check_run(input int n, input bit use_b, input string tag);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         step();
         n_assert++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL %s: scoreboard empty at cycle %0d, required an entry", tag, i);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, use_b ? obs_b : obs_a, {e.sel, e.blank, e.tick, e.frame});
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      div  = 16'd0;
      last = 3'd0;
      step();
      step();
      check("reset_a", obs_a, IdleVec);
      check("reset_b", obs_b, IdleVec);
      rst = 1'b0;
      step();
      check("idle_a", obs_a, IdleVec);

      // Basic scan: dwell 3, blank 4, digits 0..3 then wrap.
      en   = 1'b1;
      div  = 16'd2;
      last = 3'd3;
      gen(2, 3, 4, 0, 5, 1'b1);
      check_run(35, 1'b0, "basic_scan");
      exp_q.delete();
      en = 1'b0;
      step();
      check("disable_a", obs_a, IdleVec);

      // No blanking, 1-cycle dwell: select increments every cycle.
      en   = 1'b1;
      div  = 16'd0;
      last = 3'd7;
      gen(0, 7, 0, 0, 10, 1'b1);
      check_run(10, 1'b1, "no_blank");
      exp_q.delete();
      en = 1'b0;
      step();
      check("disable_b", obs_b, IdleVec);

      // Shrink i_last while on digit 5.
      en   = 1'b1;
      div  = 16'd0;
      last = 3'd7;
      gen(0, 7, 4, 0, 6, 1'b1);
      check_run(26, 1'b0, "pre_shrink");
      last = 3'd2;
      check_run(4, 1'b0, "pre_shrink_blank");
      gen(0, 2, 4, 0, 4, 1'b1);
      check_run(20, 1'b0, "post_shrink");
      exp_q.delete();
      en = 1'b0;
      step();
      check("idle_after_shrink", obs_a, IdleVec);

      // Disable during the dwell of digit 4, then re-enable.
      en   = 1'b1;
      div  = 16'd3;
      last = 3'd7;
      gen(3, 7, 4, 0, 5, 1'b1);
      check_run(33, 1'b0, "to_digit4");
      exp_q.delete();
      en = 1'b0;
      step();
      check("disable_mid_dwell", obs_a, IdleVec);
      step();
      check("stay_idle", obs_a, IdleVec);
      en = 1'b1;
      step();
      check("reenable", obs_a, 6'b000_0_1_1);

      // i_div change mid-dwell only affects the next digit.
      en = 1'b0;
      step();
      en  = 1'b1;
      div = 16'd9;
      gen(9, 7, 4, 0, 1, 1'b1);
      gen(1, 7, 4, 1, 2, 1'b0);
      check_run(1, 1'b0, "div_change");
      div = 16'd1;
      check_run(25, 1'b0, "div_change");
      exp_q.delete();

      // Asynchronous reset mid-cycle while scanning.
      step();
      step();
      #3;
      rst = 1'b1;
      #1;
      check("async_reset_a", obs_a, IdleVec);
      check("async_reset_b", obs_b, IdleVec);
      en = 1'b0;
      step();
      rst = 1'b0;
      step();
      check("after_reset", obs_a, IdleVec);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
